nibble_serial_adder: RTL

- Multi-word add controller that sits directly upstream of the team's 4-bit ripple_adder and consumes its sum/cout.
- Accepts a wide operand pair over a valid/ready handshake and feeds the adder one nibble per cycle, LSB nibble first.
- Chains the carry through a register and assembles the wide result, which it presents on an output valid/ready handshake.
- One ripple_adder instance is connected externally through the add_* ports.

---
 rtl/nibble_serial_adder.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
// Multi-word add controller that drives an external 4-bit ripple adder one
// nibble per cycle, LSB nibble first. The carry is chained through a register,
// and the wide result is presented on a valid/ready output handshake.
// Optional feature macro: NIBBLE_SERIAL_ADDER_OVF_EN adds the out_ovf port,
// which reports signed two's-complement overflow of the W-bit add.

`timescale 1ns/1ps

module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   in_a,
    input  logic [4*NIBBLES-1:0]   in_b,
    input  logic                   in_cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   out_sum,
    output logic                   out_cout,
    output logic [3:0]             add_a,
    output logic [3:0]             add_b,
    output logic                   add_cin,
    input  logic [3:0]             add_sum,
    input  logic                   add_cout
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    ,
    output logic                   out_ovf
`endif
);

    localparam int W  = 4 * NIBBLES;
    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;

    logic [W-1:0]    a_sh_reg;
    logic [W-1:0]    b_sh_reg;
    logic            carry_reg;
    logic [CW-1:0]   cnt_reg;
    logic [W-1:0]    out_sum_reg;
    logic            out_cout_reg;

    // Full result as it would look if the current RUN cycle were the last one:
    // the nibble being added now sits on top of the nibbles already collected.
    logic [W-1:0]    sum_full;

    logic            accept;
    logic            run_step;
    logic            last_step;

    assign accept    = in_valid & in_ready;
    assign run_step  = (state_reg == RUN);
    assign last_step = run_step & (cnt_reg == LAST_CNT);

    assign out_sum   = out_sum_reg;
    assign out_cout  = out_cout_reg;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic, handshake outputs and adder drive
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        add_a      = 4'd0;
        add_b      = 4'd0;
        add_cin    = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                add_a   = a_sh_reg[3:0];
                add_b   = b_sh_reg[3:0];
                add_cin = carry_reg;
                if (cnt_reg == LAST_CNT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand shift registers: load on accept, drop the consumed nibble each RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh_reg <= '0;
            b_sh_reg <= '0;
        end else if (accept) begin
            a_sh_reg <= in_a;
            b_sh_reg <= in_b;
        end else if (run_step) begin
            a_sh_reg <= a_sh_reg >> 4;
            b_sh_reg <= b_sh_reg >> 4;
        end
    end

    // Carry chain register: seeded with in_cin, then the adder's carry-out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_reg <= 1'b0;
        end else if (accept) begin
            carry_reg <= in_cin;
        end else if (run_step) begin
            carry_reg <= add_cout;
        end
    end

    // Nibble counter: position of the nibble being added in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (accept) begin
            cnt_reg <= '0;
        end else if (run_step && !last_step) begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    // Partial-result collection. A single-nibble build has nothing to collect,
    // so the adder output is the whole result.
    generate
        if (NIBBLES == 1) begin : g_single
            assign sum_full = add_sum;
        end else begin : g_multi
            logic [W-5:0] partial_reg;

            assign sum_full = {add_sum, partial_reg};

            // Shift each finished nibble in from the top so nibble 0 ends at the bottom
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    partial_reg <= '0;
                end else if (accept) begin
                    partial_reg <= '0;
                end else if (run_step) begin
                    partial_reg <= sum_full[W-1:4];
                end
            end
        end
    endgenerate

    // Result registers: only updated when a new result completes, so the
    // previous result stays visible through the next RUN phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum_reg  <= '0;
            out_cout_reg <= 1'b0;
        end else if (last_step) begin
            out_sum_reg  <= sum_full;
            out_cout_reg <= add_cout;
        end
    end

`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    logic a_msb_reg;
    logic b_msb_reg;
    logic out_ovf_reg;

    assign out_ovf = out_ovf_reg;

    // Operand sign bits, captured at accept because the shift registers lose them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_reg <= 1'b0;
            b_msb_reg <= 1'b0;
        end else if (accept) begin
            a_msb_reg <= in_a[W-1];
            b_msb_reg <= in_b[W-1];
        end
    end

    // Signed overflow: like-signed operands giving a differently signed result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_ovf_reg <= 1'b0;
        end else if (last_step) begin
            out_ovf_reg <= (a_msb_reg == b_msb_reg) && (add_sum[3] != a_msb_reg);
        end
    end
`endif

endmodule
